// File: rtl/lock_key_loader.sv
// lock_key_loader: streams the c499 unlock key in word by word, verifies an
// XOR checksum, and only then presents the key to the locked netlist.
// The key bus is held at zero in every state except ARMED.
module lock_key_loader #(
    parameter int KEY_W   = 43,
    parameter int WORD_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    input  logic              kin_valid,
    input  logic [WORD_W-1:0] kin_data,
    output logic              kin_ready,
    output logic [KEY_W-1:0]  key_out,
    output logic              key_valid,
    output logic              busy,
    output logic              fault
);

    localparam int NWORDS = (KEY_W + WORD_W - 1) / WORD_W;
    localparam int WC_W   = $clog2(NWORDS + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_ARMED = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t            state;
    state_t            nxt;
    logic [KEY_W-1:0]  shadow;
    logic [WC_W-1:0]   wcnt;
    logic [WORD_W-1:0] run_sum;
    logic [WORD_W-1:0] cap_sum;
    logic [TO_W-1:0]   tcnt;
    logic              xfer;

    // kin_ready is a registered copy of (state == LOAD), so this is a
    // handshake on registered state only.
    assign xfer = kin_valid && kin_ready;

    // Next-state decision; clear outranks everything, including a transfer.
    always_comb begin
        nxt = state;
        if (clear) begin
            nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) nxt = S_LOAD;
                S_LOAD: begin
                    if (xfer && (wcnt == WC_W'(NWORDS)))
                        nxt = S_CHECK;
                    else if (!xfer && (tcnt == TO_W'(TIMEOUT - 1)))
                        nxt = S_FAULT;
                end
                S_CHECK: nxt = (cap_sum == run_sum) ? S_ARMED : S_FAULT;
                S_ARMED: if (start) nxt = S_LOAD;
                S_FAULT: nxt = S_FAULT;
                default: nxt = S_IDLE;
            endcase
        end
    end

    // State, datapath registers and registered outputs derived from nxt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            shadow    <= '0;
            wcnt      <= '0;
            run_sum   <= '0;
            cap_sum   <= '0;
            tcnt      <= '0;
            kin_ready <= 1'b0;
            key_out   <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= nxt;
            kin_ready <= (nxt == S_LOAD);
            busy      <= (nxt == S_LOAD) || (nxt == S_CHECK);
            key_valid <= (nxt == S_ARMED);
            fault     <= (nxt == S_FAULT);
            // Shadow only reaches the bus once the checksum has been verified.
            key_out   <= (nxt == S_ARMED) ? shadow : '0;

            if (clear || (state != S_LOAD && nxt == S_LOAD)) begin
                // Zeroize on clear and on every fresh (re)load so no residue
                // from an earlier or aborted key survives.
                shadow  <= '0;
                wcnt    <= '0;
                run_sum <= '0;
                cap_sum <= '0;
                tcnt    <= '0;
            end else if (state == S_LOAD) begin
                if (xfer) begin
                    tcnt <= '0;
                    if (wcnt < WC_W'(NWORDS)) begin
                        // Key word: bits past KEY_W are dropped from the
                        // shadow, but the whole word feeds the checksum.
                        for (int b = 0; b < KEY_W; b++) begin
                            if (int'(wcnt) == (b / WORD_W))
                                shadow[b] <= kin_data[b % WORD_W];
                        end
                        run_sum <= run_sum ^ kin_data;
                        wcnt    <= wcnt + 1'b1;
                    end else begin
                        cap_sum <= kin_data;
                    end
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

endmodule
